// File: rtl/booth_pkg.sv
// Shared types and size helpers for the sequential Booth multiplier.
// Define BOOTH_RADIX4_EN to select radix-4 recoding; otherwise radix-2.
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef struct packed {
    logic neg;
    logic dbl;
    logic zero;
  } digit_sel_t;

  localparam digit_sel_t SelZero = 3'b001;
  localparam digit_sel_t SelAdd1 = 3'b000;
  localparam digit_sel_t SelSub1 = 3'b100;
  localparam digit_sel_t SelAdd2 = 3'b010;
  localparam digit_sel_t SelSub2 = 3'b110;

  // Width of the extended operands.
  function automatic int unsigned calc_xw(int unsigned width);
`ifdef BOOTH_RADIX4_EN
    return width + 2;
`else
    return width + 1;
`endif
  endfunction

  // Number of RUN iterations.
  function automatic int unsigned calc_iters(int unsigned width);
`ifdef BOOTH_RADIX4_EN
    return (width + 2) / 2;
`else
    return width + 1;
`endif
  endfunction

  function automatic int unsigned calc_shift();
`ifdef BOOTH_RADIX4_EN
    return 2;
`else
    return 1;
`endif
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Booth digit recoder: maps a 3-bit multiplier window to {neg, dbl, zero} selects.
module booth_recode
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output digit_sel_t sel
);

  // A radix-2 window {q0, q_m1} sign-extended to {q0, q0, q_m1} lands on the
  // 0/+1/-1 rows of this table, so one table serves both radices.
  always_comb begin
    sel = SelZero;
    unique case (window)
      3'b000:  sel = SelZero;
      3'b001:  sel = SelAdd1;
      3'b010:  sel = SelAdd1;
      3'b011:  sel = SelAdd2;
      3'b100:  sel = SelSub2;
      3'b101:  sel = SelSub1;
      3'b110:  sel = SelSub1;
      3'b111:  sel = SelZero;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential Booth multiplier with signed/unsigned mode and start/busy/done handshake.
// Build option: define BOOTH_RADIX4_EN for radix-4 recoding (WIDTH must then be even).
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     Q,
  input  logic [WIDTH-1:0]     M,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned XW = calc_xw(WIDTH);
  localparam int unsigned N  = calc_iters(WIDTH);
  localparam int unsigned SH = calc_shift();
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned FW = 2 * XW + 2;
  localparam int unsigned PW = 2 * WIDTH;

  if (WIDTH < 2) begin : g_bad_width
    $error("booth_mul_seq: WIDTH must be at least 2");
  end
`ifdef BOOTH_RADIX4_EN
  if (WIDTH % 2 != 0) begin : g_odd_width
    $error("booth_mul_seq: radix-4 build requires an even WIDTH");
  end
`endif

  state_e state_q, state_d;

  logic [XW:0]    a_q;
  logic [XW-1:0]  qr_q;
  logic           qm1_q;
  logic [XW-1:0]  m_q;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  product_q;

  logic           load;
  logic [XW-1:0]  q_ext, m_ext;
  logic [2:0]     window;
  digit_sel_t     sel;
  logic [XW:0]    mult, sum;
  logic [FW-1:0]  full;
  logic signed [FW-1:0] shifted;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == '0) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  assign load  = start && (state_q != StRun);
  assign q_ext = {{(XW - WIDTH){tc & Q[WIDTH-1]}}, Q};
  assign m_ext = {{(XW - WIDTH){tc & M[WIDTH-1]}}, M};

`ifdef BOOTH_RADIX4_EN
  assign window = {qr_q[1:0], qm1_q};
`else
  assign window = {qr_q[0], qr_q[0], qm1_q};
`endif

  booth_recode u_recode (
    .window (window),
    .sel    (sel)
  );

  always_comb begin
    mult = '0;
    if (!sel.zero) mult = sel.dbl ? {m_q, 1'b0} : {m_q[XW-1], m_q};
  end

  assign sum     = sel.neg ? (a_q - mult) : (a_q + mult);
  assign full    = {sum, qr_q, qm1_q};
  assign shifted = $signed(full) >>> SH;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q       <= '0;
      qr_q      <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (load) begin
      a_q   <= '0;
      qr_q  <= q_ext;
      qm1_q <= 1'b0;
      m_q   <= m_ext;
      cnt_q <= CW'(N - 1);
    end else if (state_q == StRun) begin
      a_q   <= shifted[FW-1 -: XW+1];
      qr_q  <= shifted[XW:1];
      qm1_q <= shifted[0];
      cnt_q <= cnt_q - CW'(1);
      // Final iteration: capture the low half of the shifted {A, Qreg}.
      if (cnt_q == '0) product_q <= shifted[PW:1];
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed handshake cases plus a random sweep
// on WIDTH=6 and WIDTH=8 instances against an integer-arithmetic reference.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic        start6, tc6, busy6, done6;
  logic [5:0]  q6, m6;
  logic [11:0] prod6;
  logic        start8, tc8, busy8, done8;
  logic [7:0]  q8, m8;
  logic [15:0] prod8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  booth_mul_seq #(.WIDTH(6)) u_dut6 (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start6),
    .tc      (tc6),
    .Q       (q6),
    .M       (m6),
    .busy    (busy6),
    .done    (done6),
    .product (prod6)
  );

  booth_mul_seq #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start8),
    .tc      (tc8),
    .Q       (q8),
    .M       (m8),
    .busy    (busy8),
    .done    (done8),
    .product (prod8)
  );

  function automatic int iters(int w);
`ifdef BOOTH_RADIX4_EN
    return (w + 2) / 2;
`else
    return w + 1;
`endif
  endfunction

  // Reference: interpret operands per tc, multiply as integers, keep 2*w bits.
  function automatic logic [15:0] ref_mul(int w, bit tcv, logic [7:0] qv, logic [7:0] mv);
    longint span, a, b, p;
    span = longint'(1) << w;
    a = longint'(qv) & (span - 1);
    b = longint'(mv) & (span - 1);
    if (tcv && a >= span / 2) a = a - span;
    if (tcv && b >= span / 2) b = b - span;
    p = (a * b) & ((longint'(1) << (2 * w)) - 1);
    return p[15:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(int w);
    return (w == 6) ? done6 : done8;
  endfunction

  function automatic logic get_busy(int w);
    return (w == 6) ? busy6 : busy8;
  endfunction

  function automatic logic [15:0] get_prod(int w);
    return (w == 6) ? {4'h0, prod6} : prod8;
  endfunction

  task automatic set_start(input int w, input bit v);
    if (w == 6) start6 = v;
    else        start8 = v;
  endtask

  task automatic drive(input int w, input bit tcv, input logic [7:0] qv, input logic [7:0] mv);
    if (w == 6) begin
      start6 = 1'b1; tc6 = tcv; q6 = qv[5:0]; m6 = mv[5:0];
    end else begin
      start8 = 1'b1; tc8 = tcv; q8 = qv; m8 = mv;
    end
  endtask

  // Called on the negedge where start was raised; returns on the negedge done is seen.
  task automatic wait_done(input int w, input string tag, input logic [15:0] exp);
    int lat = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) begin
        set_start(w, 1'b0);
        check({tag, " busy"}, 64'(get_busy(w)), 64'd1);
      end
      if (get_done(w)) begin
        lat = j;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(iters(w) + 1));
    check({tag, " product"}, 64'(get_prod(w)), 64'(exp));
    check({tag, " busy at done"}, 64'(get_busy(w)), 64'd0);
  endtask

  task automatic op(input int w, input bit tcv, input logic [7:0] qv, input logic [7:0] mv,
                    input string tag);
    logic [15:0] exp;
    exp = ref_mul(w, tcv, qv, mv);
    drive(w, tcv, qv, mv);
    wait_done(w, tag, exp);
    @(negedge clk);
    check({tag, " done pulse"}, 64'(get_done(w)), 64'd0);
    check({tag, " held"}, 64'(get_prod(w)), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dones;
    bit tcv;
    logic [7:0] qv, mv;

    n_rst = 1'b0;
    start6 = 1'b0; tc6 = 1'b0; q6 = '0; m6 = '0;
    start8 = 1'b0; tc8 = 1'b0; q8 = '0; m8 = '0;
    repeat (2) @(negedge clk);
    check("reset busy6", 64'(busy6), 64'd0);
    check("reset done6", 64'(done6), 64'd0);
    check("reset prod6", 64'(prod6), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset prod8", 64'(prod8), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    op(6, 1'b1, 8'd30, 8'hF4, "s30xm12");
    check("s30xm12 const", 64'(prod6), 64'hE98);
    op(6, 1'b0, 8'h3F, 8'h3F, "u63x63");
    check("u63x63 const", 64'(prod6), 64'hF81);
    op(6, 1'b1, 8'h20, 8'h20, "min sq");
    check("min sq const", 64'(prod6), 64'h400);

    // start held high while busy with a different operand set
    drive(6, 1'b1, 8'd30, 8'hF4);
    dones = 0;
    for (int j = 1; j <= iters(6) + 6; j++) begin
      @(negedge clk);
      if (j >= 2 && j <= 4) begin
        start6 = 1'b1; tc6 = 1'b0; q6 = 6'h15; m6 = 6'h0B;
      end else begin
        start6 = 1'b0;
      end
      if (done6) dones++;
    end
    check("held start dones", 64'(dones), 64'd1);
    check("held start prod", 64'(prod6), 64'hE98);
    check("held start busy", 64'(busy6), 64'd0);

    // back-to-back issue in the DONE cycle
    drive(6, 1'b0, 8'h3F, 8'h3F);
    wait_done(6, "b2b first", 16'h0F81);
    drive(6, 1'b1, 8'h20, 8'h20);
    wait_done(6, "b2b second", 16'h0400);
    @(negedge clk);
    check("b2b done pulse", 64'(done6), 64'd0);

    // reset in the middle of RUN
    drive(6, 1'b1, 8'h1F, 8'h1F);
    @(negedge clk);
    start6 = 1'b0;
    @(negedge clk);
    check("abort busy before", 64'(busy6), 64'd1);
    n_rst = 1'b0;
    #1;
    check("abort busy", 64'(busy6), 64'd0);
    check("abort done", 64'(done6), 64'd0);
    check("abort prod", 64'(prod6), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    dones = 0;
    for (int j = 0; j < iters(6) + 4; j++) begin
      @(negedge clk);
      if (done6) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    check("abort idle", 64'(busy6), 64'd0);

    // random sweep on both widths and both modes
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 2; k++) begin
        tcv = 1'($urandom_range(1, 0));
        qv  = 8'($urandom);
        mv  = 8'($urandom);
        if (i % 8 == 0) begin
          qv = (k == 0) ? 8'h20 : 8'h80;
          mv = (i % 16 == 0) ? qv : 8'hFF;
        end
        op((k == 0) ? 6 : 8, tcv, qv, mv, (k == 0) ? "rand w6" : "rand w8");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
